sa_host_xfer: RTL

// - Host-side transfer engine for sa_matmul; it is the writer for the buffers the matmul reads.
// - Takes a valid/ready beat stream and writes it into the weight buffer, then the input buffer.
// - Then pulses the matmul start, waits for done, and reads the output buffer back out as a stream.
// - Sits in sa_top between the host stream interface and the three mem_emulator/SRAM buffers.
// - Buffer ports are shared with sa_matmul; sa_top muxes them using mem_own_o.

---
 rtl/sa_pkg.sv | 22 ++
 rtl/sa_skid_fifo.sv | 62 ++++++
 rtl/sa_host_xfer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types and sizing helpers for the systolic-array host transfer engine
package sa_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_I,
        S_START,
        S_WAIT_MM,
        S_DRAIN,
        S_FIN
    } xfer_state_e;

    function automatic integer clog2_1(input integer n);
        return $clog2(n + 1);
    endfunction

    function automatic integer bus_w(input integer row, input integer col, input integer width);
        return ((row > col) ? row : col) * width;
    endfunction

endpackage

// File: rtl/sa_skid_fifo.sv
// rtl/sa_skid_fifo.sv - small valid/ready FIFO that absorbs output-buffer read data under backpressure
module sa_skid_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [WIDTH-1:0]             in_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [WIDTH-1:0]             out_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign in_ready_o  = (r_count != CW'(DEPTH));
    assign out_valid_o = (r_count != '0);
    assign out_data_o  = r_mem[r_rd_ptr];
    assign count_o     = r_count;
    assign w_push      = in_valid_i && in_ready_o;
    assign w_pop       = out_valid_o && out_ready_i;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data_i;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sa_host_xfer.sv
// rtl/sa_host_xfer.sv - loads weight/input buffers from a beat stream, kicks the matmul, streams the output buffer back
module sa_host_xfer
    import sa_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ROW    = 3,
    parameter int COL    = 3,
    parameter int I_SIZE = 5,
    parameter int W_SIZE = 3,
    parameter int O_SIZE = 5
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               cmd_start_i,
    input  logic [clog2_1(W_SIZE)-1:0]         w_len_i,
    input  logic [clog2_1(I_SIZE)-1:0]         i_len_i,
    input  logic [clog2_1(O_SIZE)-1:0]         o_len_i,
    input  logic                               s_valid_i,
    output logic                               s_ready_o,
    input  logic [bus_w(ROW, COL, WIDTH)-1:0]  s_data_i,
    output logic                               m_valid_o,
    input  logic                               m_ready_i,
    output logic [COL*WIDTH-1:0]               m_data_o,
    output logic                               wb_mem_cenb_o,
    output logic                               wb_mem_wenb_o,
    output logic [$clog2(W_SIZE)-1:0]          wb_mem_addr_o,
    output logic [COL*WIDTH-1:0]               wb_mem_data_o,
    output logic                               ib_mem_cenb_o,
    output logic                               ib_mem_wenb_o,
    output logic [$clog2(I_SIZE)-1:0]          ib_mem_addr_o,
    output logic [ROW*WIDTH-1:0]               ib_mem_data_o,
    output logic                               ob_mem_cenb_o,
    output logic                               ob_mem_wenb_o,
    output logic [$clog2(O_SIZE)-1:0]          ob_mem_addr_o,
    input  logic [COL*WIDTH-1:0]               ob_mem_data_i,
    output logic                               mm_start_o,
    input  logic                               mm_done_i,
    output logic                               mem_own_o,
    output logic                               busy_o,
    output logic                               done_o
);

    localparam int WLW = clog2_1(W_SIZE);
    localparam int ILW = clog2_1(I_SIZE);
    localparam int OLW = clog2_1(O_SIZE);
    localparam int BW  = (WLW > ILW) ? WLW : ILW;
    localparam int WAW = $clog2(W_SIZE);
    localparam int IAW = $clog2(I_SIZE);
    localparam int OAW = $clog2(O_SIZE);
    localparam int OW  = COL * WIDTH;
    localparam int IW  = ROW * WIDTH;

    xfer_state_e      r_state;
    xfer_state_e      w_next;
    logic [WLW-1:0]   r_w_len;
    logic [ILW-1:0]   r_i_len;
    logic [OLW-1:0]   r_o_len;
    logic [BW-1:0]    r_beat;
    logic [OLW-1:0]   r_rd_cnt;
    logic [OLW-1:0]   r_out_cnt;
    logic             r_rd_valid;
    logic             r_done_q;
    logic [WLW-1:0]   w_w_len_c;
    logic [ILW-1:0]   w_i_len_c;
    logic [OLW-1:0]   w_o_len_c;
    logic [BW-1:0]    w_phase_len;
    logic             w_accept;
    logic             w_beat_last;
    logic             w_done_edge;
    logic             w_issue;
    logic             w_pop;
    logic             w_fifo_in_ready;
    logic [1:0]       w_fifo_cnt;
    logic [2:0]       w_slots;

    assign w_w_len_c = (w_len_i > WLW'(W_SIZE)) ? WLW'(W_SIZE) : w_len_i;
    assign w_i_len_c = (i_len_i > ILW'(I_SIZE)) ? ILW'(I_SIZE) : i_len_i;
    assign w_o_len_c = (o_len_i > OLW'(O_SIZE)) ? OLW'(O_SIZE) : o_len_i;

    // ready drops once the phase has all its beats so nothing extra is swallowed
    assign w_phase_len = (r_state == S_LOAD_W) ? BW'(r_w_len) : BW'(r_i_len);
    assign s_ready_o   = ((r_state == S_LOAD_W) || (r_state == S_LOAD_I)) && (r_beat < w_phase_len);
    assign w_accept    = s_valid_i && s_ready_o;
    assign w_beat_last = w_accept && ((r_beat + BW'(1)) == w_phase_len);
    assign w_done_edge = mm_done_i && !r_done_q;

    // a popped head frees its slot this cycle, which is what sustains one beat per cycle
    assign w_pop   = m_valid_o && m_ready_i;
    assign w_slots = 3'(w_fifo_cnt) + 3'(r_rd_valid);
    assign w_issue = (r_state == S_DRAIN) && (r_rd_cnt < r_o_len) &&
                     (w_slots < (3'd2 + 3'(w_pop))) && (w_fifo_in_ready || w_pop);

    assign ob_mem_cenb_o = !w_issue;
    assign ob_mem_wenb_o = 1'b1;
    assign ob_mem_addr_o = w_issue ? OAW'(r_rd_cnt) : '0;

    assign mm_start_o = (r_state == S_START);
    assign mem_own_o  = !((r_state == S_START) || (r_state == S_WAIT_MM));
    assign busy_o     = (r_state != S_IDLE);
    assign done_o     = (r_state == S_FIN);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_start_i) begin
                    if (w_w_len_c != '0)      w_next = S_LOAD_W;
                    else if (w_i_len_c != '0) w_next = S_LOAD_I;
                    else                      w_next = S_START;
                end
            end
            S_LOAD_W:  if (w_beat_last) w_next = S_LOAD_I;
            // holds one extra cycle after the last beat so its write lands before ownership flips
            S_LOAD_I:  if (r_beat == BW'(r_i_len)) w_next = S_START;
            S_START:   w_next = S_WAIT_MM;
            S_WAIT_MM: if (w_done_edge) w_next = (r_o_len != '0) ? S_DRAIN : S_FIN;
            S_DRAIN:   if (w_pop && ((r_out_cnt + OLW'(1)) == r_o_len)) w_next = S_FIN;
            S_FIN:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_w_len       <= '0;
            r_i_len       <= '0;
            r_o_len       <= '0;
            r_beat        <= '0;
            r_rd_cnt      <= '0;
            r_out_cnt     <= '0;
            r_rd_valid    <= 1'b0;
            r_done_q      <= 1'b0;
            wb_mem_cenb_o <= 1'b1;
            wb_mem_wenb_o <= 1'b1;
            wb_mem_addr_o <= '0;
            wb_mem_data_o <= '0;
            ib_mem_cenb_o <= 1'b1;
            ib_mem_wenb_o <= 1'b1;
            ib_mem_addr_o <= '0;
            ib_mem_data_o <= '0;
        end else begin
            r_state       <= w_next;
            r_done_q      <= mm_done_i;
            r_rd_valid    <= w_issue;
            wb_mem_cenb_o <= 1'b1;
            wb_mem_wenb_o <= 1'b1;
            ib_mem_cenb_o <= 1'b1;
            ib_mem_wenb_o <= 1'b1;
            if ((r_state == S_IDLE) && cmd_start_i) begin
                r_w_len   <= w_w_len_c;
                r_i_len   <= w_i_len_c;
                r_o_len   <= w_o_len_c;
                r_beat    <= '0;
                r_rd_cnt  <= '0;
                r_out_cnt <= '0;
            end
            if (w_accept) begin
                if (r_state == S_LOAD_W) begin
                    wb_mem_cenb_o <= 1'b0;
                    wb_mem_wenb_o <= 1'b0;
                    wb_mem_addr_o <= WAW'(r_beat);
                    wb_mem_data_o <= s_data_i[OW-1:0];
                end else begin
                    ib_mem_cenb_o <= 1'b0;
                    ib_mem_wenb_o <= 1'b0;
                    ib_mem_addr_o <= IAW'(r_beat);
                    ib_mem_data_o <= s_data_i[IW-1:0];
                end
                r_beat <= (w_beat_last && (r_state == S_LOAD_W)) ? '0 : r_beat + BW'(1);
            end
            if (w_issue) begin
                r_rd_cnt <= r_rd_cnt + OLW'(1);
            end
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + OLW'(1);
            end
        end
    end

    sa_skid_fifo #(
        .WIDTH (OW),
        .DEPTH (2)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (r_rd_valid),
        .in_ready_o  (w_fifo_in_ready),
        .in_data_i   (ob_mem_data_i),
        .out_valid_o (m_valid_o),
        .out_ready_i (m_ready_i),
        .out_data_o  (m_data_o),
        .count_o     (w_fifo_cnt)
    );

endmodule
